seg_scan_ctrl: RTL

Scan controller that time-shares one `fourBitConverter` BCD-to-seven-segment decoder across a four-digit common-anode display. It sits between the system logic and the decoder. It latches a four-digit BCD word over a load handshake, rejects non-BCD digits, and drives the decoder inputs and the active-low digit anodes in a round-robin scan. A blanking gap precedes each digit to suppress ghosting.

---
 rtl/seg_scan_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: round-robin scan controller for a four-digit common-anode
// display. It shares one BCD-to-seven-segment decoder between the digits.
// Configuration macro: SEG_LZ_BLANK_EN. When defined, leading-zero digits
// stay dark during their slot. Digit 0 is always lit.
// Without the macro, every digit is lit in its own slot.
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic        load_i,
    input  logic [15:0] din_i,
    output logic        ack_o,
    output logic        err_o,
    output logic [3:0]  nib_o,
    output logic [3:0]  an_o
);

    // One counter serves both the blank gap and the lit slot.
    // It is sized for the longer of the two phases.
    localparam int MAX_CYC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic [1:0]       r_idx;
    logic [1:0]       w_nextIdx;
    logic [3:0]       r_nib;
    logic [3:0]       w_nextNib;
    logic [3:0]       r_an;
    logic [3:0]       w_nextAn;
    logic [15:0]      r_shadow;
    logic             r_ack;
    logic             r_err;
    logic             w_dinValid;
    logic [3:0]       w_shadowNib;
    logic             w_suppress;

    // A load is accepted only if every nibble is a legal BCD digit (0..9).
    assign w_dinValid = (din_i[15:12] <= 4'd9) && (din_i[11:8] <= 4'd9) &&
                        (din_i[7:4]   <= 4'd9) && (din_i[3:0]  <= 4'd9);

    // Load handshake: update the shadow word and pulse ack, or pulse err and
    // keep the old word. Loads are accepted in every scan state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= 16'h0000;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            if (load_i) begin
                if (w_dinValid) begin
                    r_shadow <= din_i;
                    r_ack    <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Select the shadow nibble for the digit that is about to be lit.
    always_comb begin
        w_shadowNib = r_shadow[3:0];
        case (r_idx)
            2'd0:    w_shadowNib = r_shadow[3:0];
            2'd1:    w_shadowNib = r_shadow[7:4];
            2'd2:    w_shadowNib = r_shadow[11:8];
            2'd3:    w_shadowNib = r_shadow[15:12];
            default: w_shadowNib = r_shadow[3:0];
        endcase
    end

`ifdef SEG_LZ_BLANK_EN
    // A digit is a leading zero when it and every more-significant digit are
    // zero. Digit 0 is never suppressed, so a value of zero still shows "0".
    always_comb begin
        w_suppress = 1'b0;
        case (r_idx)
            2'd3:    w_suppress = (r_shadow[15:12] == 4'd0);
            2'd2:    w_suppress = (r_shadow[15:8]  == 8'd0);
            2'd1:    w_suppress = (r_shadow[15:4]  == 12'd0);
            default: w_suppress = 1'b0;
        endcase
    end
`else
    assign w_suppress = 1'b0;
`endif

    // Next-state logic. Dropping en_i always parks the scan in IDLE and keeps
    // the index and the nibble. The nibble and the anode are latched together
    // at the BLANK->SHOW edge, so a load never disturbs the digit that is lit.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextIdx   = r_idx;
        w_nextNib   = r_nib;
        w_nextAn    = r_an;
        if (!en_i) begin
            w_nextState = ST_IDLE;
            w_nextCnt   = CNT_ZERO;
            w_nextAn    = 4'b1111;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nextState = ST_BLANK;
                    w_nextCnt   = CNT_ZERO;
                    w_nextAn    = 4'b1111;
                end
                ST_BLANK: begin
                    w_nextAn = 4'b1111;
                    if (r_cnt == BLANK_LAST) begin
                        w_nextState = ST_SHOW;
                        w_nextCnt   = CNT_ZERO;
                        w_nextNib   = w_shadowNib;
                        w_nextAn    = w_suppress ? 4'b1111 : ~(4'b0001 << r_idx);
                    end else begin
                        w_nextCnt = r_cnt + CNT_ONE;
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == SHOW_LAST) begin
                        w_nextState = ST_BLANK;
                        w_nextCnt   = CNT_ZERO;
                        w_nextIdx   = r_idx + 2'd1;
                        w_nextAn    = 4'b1111;
                    end else begin
                        w_nextCnt = r_cnt + CNT_ONE;
                    end
                end
                default: begin
                    w_nextState = ST_IDLE;
                    w_nextCnt   = CNT_ZERO;
                    w_nextAn    = 4'b1111;
                end
            endcase
        end
    end

    // Scan state register. The anode and nibble outputs are registered here,
    // so they change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
            r_idx   <= 2'd0;
            r_nib   <= 4'd0;
            r_an    <= 4'b1111;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_idx   <= w_nextIdx;
            r_nib   <= w_nextNib;
            r_an    <= w_nextAn;
        end
    end

    assign ack_o = r_ack;
    assign err_o = r_err;
    assign nib_o = r_nib;
    assign an_o  = r_an;

endmodule
